// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_unit
//  Brief    : Fetches 32-bit instruction words over a valid/ready read channel
//             and presents them to the core, with alignment/bus/timeout faults.
//  Revision : 1.0  initial release
// ============================================================================
module inst_fetch_unit #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic [31:0] pc_in,
   output logic        busy,
   output logic        ar_valid,
   output logic [31:0] ar_addr,
   input  logic        ar_ready,
   input  logic        r_valid,
   input  logic [31:0] r_data,
   input  logic [1:0]  r_resp,
   output logic        r_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic        fault,
   output logic [1:0]  fault_code
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] c_tmo_sat  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

   localparam logic [1:0] c_code_none  = 2'b00;
   localparam logic [1:0] c_code_align = 2'b01;
   localparam logic [1:0] c_code_bus   = 2'b10;
   localparam logic [1:0] c_code_tmo   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_R    = 2'd2,
      ST_OUT  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_accept;
   logic             w_misaligned;
   logic             w_rsp;
   logic             w_tmo;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_ar_addr;
   logic [31:0]      r_inst;
   logic [31:0]      r_inst_pc;
   logic             r_fault;
   logic [1:0]       r_fault_code;

   assign w_misaligned = |pc_in[1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_rsp       = 1'b0;
      w_tmo       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_accept = fetch_req;
         end
         ST_AR: begin
            if (ar_ready) begin
               w_state_nxt = ST_R;
            end
         end
         ST_R: begin
            if (r_valid) begin
               w_rsp       = 1'b1;
               w_state_nxt = ST_OUT;
            end else if (r_cnt == c_tmo_last) begin
               w_tmo       = 1'b1;
               w_state_nxt = ST_OUT;
            end
         end
         ST_OUT: begin
            if (inst_ready) begin
               w_accept    = fetch_req;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (w_accept) begin
         w_state_nxt = w_misaligned ? ST_OUT : ST_AR;
      end
   end

   // Counter saturates at TIMEOUT; the fault fires on the cycle it gets there.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt        <= '0;
         r_ar_addr    <= '0;
         r_inst       <= NOP_INST;
         r_inst_pc    <= '0;
         r_fault      <= 1'b0;
         r_fault_code <= c_code_none;
      end else begin
         if (r_state == ST_AR && ar_ready) begin
            r_cnt <= '0;
         end else if (r_state == ST_R && !r_valid && r_cnt != c_tmo_sat) begin
            r_cnt <= r_cnt + c_cnt_one;
         end

         if (w_accept) begin
            r_ar_addr <= pc_in;
            r_inst_pc <= pc_in;
            r_inst    <= NOP_INST;
            if (w_misaligned) begin
               r_fault      <= 1'b1;
               r_fault_code <= c_code_align;
            end else begin
               r_fault      <= 1'b0;
               r_fault_code <= c_code_none;
            end
         end else if (w_rsp) begin
            if (r_resp == 2'b00) begin
               r_inst <= r_data;
            end else begin
               r_inst       <= NOP_INST;
               r_fault      <= 1'b1;
               r_fault_code <= c_code_bus;
            end
         end else if (w_tmo) begin
            r_inst       <= NOP_INST;
            r_fault      <= 1'b1;
            r_fault_code <= c_code_tmo;
         end
      end
   end

   // Handshake strobes are decoded from state so reset clears them at once.
   assign busy       = (r_state == ST_AR) || (r_state == ST_R);
   assign ar_valid   = (r_state == ST_AR);
   assign r_ready    = (r_state == ST_R);
   assign inst_valid = (r_state == ST_OUT);
   assign ar_addr    = r_ar_addr;
   assign inst       = r_inst;
   assign inst_pc    = r_inst_pc;
   assign fault      = r_fault;
   assign fault_code = r_fault_code;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch_unit
//  Brief    : Scoreboard bench for inst_fetch_unit (TIMEOUT = 8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_inst_fetch_unit;

   localparam int unsigned c_timeout = 8;
   localparam logic [31:0] c_nop     = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        fetch_req;
   logic [31:0] pc_in;
   logic        busy;
   logic        ar_valid;
   logic [31:0] ar_addr;
   logic        ar_ready;
   logic        r_valid;
   logic [31:0] r_data;
   logic [1:0]  r_resp;
   logic        r_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic        fault;
   logic [1:0]  fault_code;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        fault;
      logic [1:0]  code;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_deliv  = 0;

   inst_fetch_unit #(
      .TIMEOUT  (c_timeout),
      .NOP_INST (c_nop)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .fetch_req  (fetch_req),
      .pc_in      (pc_in),
      .busy       (busy),
      .ar_valid   (ar_valid),
      .ar_addr    (ar_addr),
      .ar_ready   (ar_ready),
      .r_valid    (r_valid),
      .r_data     (r_data),
      .r_resp     (r_resp),
      .r_ready    (r_ready),
      .inst       (inst),
      .inst_pc    (inst_pc),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .fault      (fault),
      .fault_code (fault_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] i, input logic [31:0] pc, input logic f, input logic [1:0] c);
      exp_t e;
      e.inst  = i;
      e.pc    = pc;
      e.fault = f;
      e.code  = c;
      sb.push_back(e);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!inst_valid && n < 50) begin
         tick();
         n++;
      end
      check(tag, 64'(inst_valid), 64'd1);
   endtask

   task automatic handshake();
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
   endtask

   // Scoreboard: every consumed instruction must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && inst_valid && inst_ready) begin
         n_deliv++;
         check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("sb_inst", 64'(inst), 64'(e.inst));
            check("sb_pc", 64'(inst_pc), 64'(e.pc));
            check("sb_fault", 64'(fault), 64'(e.fault));
            check("sb_code", 64'(fault_code), 64'(e.code));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      int prev;
      rst        = 1'b1;
      fetch_req  = 1'b0;
      pc_in      = '0;
      ar_ready   = 1'b0;
      r_valid    = 1'b0;
      r_data     = '0;
      r_resp     = 2'b00;
      inst_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state
      check("rst_flags", 64'({ar_valid, r_ready, inst_valid, fault, fault_code, busy}), 64'd0);
      check("rst_inst", 64'(inst), 64'(c_nop));
      check("rst_pc", 64'(inst_pc), 64'd0);
      check("rst_addr", 64'(ar_addr), 64'd0);

      // Minimum-latency aligned fetch
      ar_ready  = 1'b1;
      r_valid   = 1'b1;
      r_data    = 32'h0010_0093;
      r_resp    = 2'b00;
      fetch_req = 1'b1;
      pc_in     = 32'h8000_0000;
      push(32'h0010_0093, 32'h8000_0000, 1'b0, 2'b00);
      tick();
      fetch_req = 1'b0;
      check("lat_c1_ar", 64'({ar_valid, busy}), 64'b11);
      check("lat_c1_addr", 64'(ar_addr), 64'h8000_0000);
      tick();
      check("lat_c2_r", 64'({ar_valid, r_ready, inst_valid}), 64'b010);
      tick();
      check("lat_c3_valid", 64'({inst_valid, busy}), 64'b10);
      check("lat_c3_inst", 64'(inst), 64'h0010_0093);
      handshake();
      check("lat_idle", 64'({inst_valid, busy}), 64'b00);

      // Address channel stall with ignored requests
      ar_ready  = 1'b0;
      r_data    = 32'h0020_0113;
      fetch_req = 1'b1;
      pc_in     = 32'h8000_0010;
      push(32'h0020_0113, 32'h8000_0010, 1'b0, 2'b00);
      prev = n_deliv;
      tick();
      for (int i = 0; i < 4; i++) begin
         check("stall_ar", 64'({ar_valid, busy}), 64'b11);
         check("stall_addr", 64'(ar_addr), 64'h8000_0010);
         fetch_req = (i % 2 == 0);
         pc_in     = 32'h9000_0000 + 32'(i);
         tick();
      end
      fetch_req = 1'b0;
      check("stall_ar_end", 64'(ar_valid), 64'd1);
      ar_ready = 1'b1;
      wait_valid("stall_valid");
      handshake();
      repeat (3) tick();
      check("stall_count", 64'(n_deliv), 64'(prev + 1));
      check("stall_no_extra", 64'(inst_valid), 64'd0);

      // Misaligned address
      fetch_req = 1'b1;
      pc_in     = 32'h8000_0002;
      push(c_nop, 32'h8000_0002, 1'b1, 2'b01);
      tick();
      fetch_req = 1'b0;
      check("mis_no_ar", 64'(ar_valid), 64'd0);
      check("mis_out", 64'({inst_valid, fault, fault_code}), 64'b1101);
      check("mis_inst", 64'(inst), 64'(c_nop));
      handshake();

      // Bus error response
      r_resp    = 2'b10;
      r_data    = 32'hDEAD_BEEF;
      fetch_req = 1'b1;
      pc_in     = 32'h8000_0020;
      push(c_nop, 32'h8000_0020, 1'b1, 2'b10);
      tick();
      fetch_req = 1'b0;
      wait_valid("err_valid");
      check("err_inst", 64'(inst), 64'(c_nop));
      handshake();
      r_resp = 2'b00;

      // Response timeout, then a stray response
      r_valid   = 1'b0;
      fetch_req = 1'b1;
      pc_in     = 32'h8000_0030;
      push(c_nop, 32'h8000_0030, 1'b1, 2'b11);
      tick();
      fetch_req = 1'b0;
      tick();
      cyc = 0;
      while (r_ready && cyc < 40) begin
         cyc++;
         tick();
      end
      check("tmo_r_cycles", 64'(cyc), 64'(c_timeout));
      check("tmo_out", 64'({inst_valid, r_ready, fault, fault_code}), 64'b10111);
      r_valid = 1'b1;
      r_data  = 32'h1234_5678;
      tick();
      r_valid = 1'b0;
      check("tmo_stray_inst", 64'(inst), 64'(c_nop));
      check("tmo_stray_flags", 64'({inst_valid, r_ready, fault_code}), 64'b1011);
      handshake();

      // Consumer stall, then back-to-back fetch
      r_valid   = 1'b1;
      r_data    = 32'h0030_0193;
      fetch_req = 1'b1;
      pc_in     = 32'h8000_0000;
      push(32'h0030_0193, 32'h8000_0000, 1'b0, 2'b00);
      tick();
      fetch_req = 1'b0;
      wait_valid("b2b_first_valid");
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_out_valid", 64'(inst_valid), 64'd1);
         check("stall_out_inst", 64'(inst), 64'h0030_0193);
         check("stall_out_pc", 64'(inst_pc), 64'h8000_0000);
      end
      inst_ready = 1'b1;
      fetch_req  = 1'b1;
      pc_in      = 32'h8000_0004;
      r_data     = 32'h0040_0213;
      push(32'h0040_0213, 32'h8000_0004, 1'b0, 2'b00);
      tick();
      inst_ready = 1'b0;
      fetch_req  = 1'b0;
      check("b2b_ar", 64'({ar_valid, inst_valid}), 64'b10);
      check("b2b_addr", 64'(ar_addr), 64'h8000_0004);
      tick();
      tick();
      check("b2b_c3_valid", 64'(inst_valid), 64'd1);
      handshake();

      // Asynchronous reset in the middle of R
      r_valid   = 1'b0;
      fetch_req = 1'b1;
      pc_in     = 32'h8000_0008;
      tick();
      fetch_req = 1'b0;
      tick();
      check("rst_mid_in_r", 64'(r_ready), 64'd1);
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid_flags", 64'({ar_valid, r_ready, inst_valid, fault, fault_code, busy}), 64'd0);
      check("rst_mid_inst", 64'(inst), 64'(c_nop));
      check("rst_mid_pc", 64'({inst_pc, ar_addr}), 64'd0);
      tick();
      rst = 1'b0;
      tick();

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
